// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single-port-style memory
// that has separate read/write address buses and a registered read path
// (one-cycle latency).
//
// Ports
//   clock, reset                  single clock, synchronous active-high reset
//   req_n, we_n, addr_n, wdata_n  requester n access (n = 0, 1), held until ack_n
//   lock_n                        requester n wants to keep ownership
//   ack_n                         combinational, access accepted this cycle
//   rvalid_n, rdata_n             read data return, one cycle after a read ack
//   mem_read_addr, mem_write_addr, mem_write_data, mem_write_ctrl  memory side
//   mem_read_out                  registered memory read data
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | open arbitration; ties go to the requester that was not last_grant
// OWN0  | requester 0 holds a locked burst; requester 1 waits
// OWN1  | requester 1 holds a locked burst; requester 0 waits
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_0,
  input  logic                  req_1,
  input  logic                  we_0,
  input  logic                  we_1,
  input  logic [ADDR_WIDTH-1:0] addr_0,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [DATA_WIDTH-1:0] wdata_0,
  input  logic [DATA_WIDTH-1:0] wdata_1,
  input  logic                  lock_0,
  input  logic                  lock_1,
  output logic                  ack_0,
  output logic                  ack_1,
  output logic                  rvalid_0,
  output logic                  rvalid_1,
  output logic [DATA_WIDTH-1:0] rdata_0,
  output logic [DATA_WIDTH-1:0] rdata_1,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_ctrl,
  input  logic [DATA_WIDTH-1:0] mem_read_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  localparam logic [4:0] BURST_MAX = 5'(MAX_BURST);

  logic [1:0] state, state_nxt;
  logic       last_grant, last_grant_nxt;
  logic [4:0] burst_cnt, burst_cnt_nxt;
  logic [4:0] cnt_inc;
  logic       gnt_valid, gnt_idx;
  logic       grant;
  logic       own_idx, own_req, own_lock;
  logic       rvalid_q0, rvalid_q1;

  assign own_idx  = (state == OWN1);
  assign own_req  = own_idx ? req_1 : req_0;
  assign own_lock = own_idx ? lock_1 : lock_0;
  assign cnt_inc  = burst_cnt + 5'd1;

  always_comb begin
    gnt_valid      = 1'b0;
    gnt_idx        = 1'b0;
    state_nxt      = state;
    last_grant_nxt = last_grant;
    burst_cnt_nxt  = burst_cnt;
    case (state)
      IDLE: begin
        if (req_0 && req_1) begin
          gnt_valid = 1'b1;
          gnt_idx   = ~last_grant;
        end else if (req_0) begin
          gnt_valid = 1'b1;
          gnt_idx   = 1'b0;
        end else if (req_1) begin
          gnt_valid = 1'b1;
          gnt_idx   = 1'b1;
        end
        if (gnt_valid) begin
          last_grant_nxt = gnt_idx;
          if ((gnt_idx ? lock_1 : lock_0) && (MAX_BURST > 1)) begin
            state_nxt     = gnt_idx ? OWN1 : OWN0;
            burst_cnt_nxt = 5'd1;
          end
        end
      end
      OWN0, OWN1: begin
        last_grant_nxt = own_idx;
        // The limit is checked on the current count before counting this
        // beat, so the counter can never run past MAX_BURST.
        if (own_req && (burst_cnt < BURST_MAX)) begin
          gnt_valid = 1'b1;
          gnt_idx   = own_idx;
          if (!own_lock || (cnt_inc >= BURST_MAX)) begin
            state_nxt     = IDLE;
            burst_cnt_nxt = 5'd0;
          end else begin
            burst_cnt_nxt = cnt_inc;
          end
        end else begin
          // Owner went quiet: give up the lock with a dead cycle.
          state_nxt     = IDLE;
          burst_cnt_nxt = 5'd0;
        end
      end
      default: begin
        state_nxt     = IDLE;
        burst_cnt_nxt = 5'd0;
      end
    endcase
  end

  // A cycle with reset high never accepts anything.
  assign grant = gnt_valid & ~reset;
  assign ack_0 = grant & ~gnt_idx;
  assign ack_1 = grant & gnt_idx;

  assign mem_read_addr  = gnt_idx ? addr_1 : addr_0;
  assign mem_write_addr = gnt_idx ? addr_1 : addr_0;
  assign mem_write_data = gnt_idx ? wdata_1 : wdata_0;
  assign mem_write_ctrl = grant & (gnt_idx ? we_1 : we_0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      burst_cnt  <= 5'd0;
      rvalid_q0  <= 1'b0;
      rvalid_q1  <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      burst_cnt  <= burst_cnt_nxt;
      rvalid_q0  <= ack_0 & ~we_0;
      rvalid_q1  <= ack_1 & ~we_1;
    end
  end

  // Masking with reset drops the return of a read accepted just before reset.
  assign rvalid_0 = rvalid_q0 & ~reset;
  assign rvalid_1 = rvalid_q1 & ~reset;
  assign rdata_0  = rvalid_0 ? mem_read_out : '0;
  assign rdata_1  = rvalid_1 ? mem_read_out : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_0, req_1, we_0, we_1, lock_0, lock_1;
  logic [15:0] addr_0, addr_1, wdata_0, wdata_1;
  logic        ack_0, ack_1, rvalid_0, rvalid_1;
  logic [15:0] rdata_0, rdata_1;
  logic [15:0] mem_read_addr, mem_write_addr, mem_write_data;
  logic        mem_write_ctrl;
  logic [15:0] mem_read_out;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MAX_BURST(4)) dut (
    .clock(clock), .reset(reset),
    .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
    .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
    .lock_0(lock_0), .lock_1(lock_1),
    .ack_0(ack_0), .ack_1(ack_1), .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
    .rdata_0(rdata_0), .rdata_1(rdata_1),
    .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .mem_write_ctrl(mem_write_ctrl),
    .mem_read_out(mem_read_out)
  );

  // Memory model: word i starts as 16'hA000 + i, registered read.
  logic [15:0] mem [0:255];
  bit          mem_ready = 1'b0;
  always @(posedge clock) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 + 16'(i);
      mem_ready <= 1'b1;
    end else if (mem_write_ctrl) begin
      mem[mem_write_addr[7:0]] <= mem_write_data;
    end
    mem_read_out <= mem[mem_read_addr[7:0]];
  end

  typedef struct {
    logic        rst, r0, r1, w0, w1, l0, l1;
    logic [15:0] a0, a1, d0, d1;
    logic        e_ack0, e_ack1, e_wc, e_rv0, e_rv1;
    logic [15:0] e_rd0, e_rd1;
  } vec_t;

  localparam int NV = 20;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic rst, input logic r0, input logic r1,
                       input logic w0, input logic w1, input logic l0, input logic l1,
                       input logic [15:0] a0, input logic [15:0] a1,
                       input logic [15:0] d0, input logic [15:0] d1);
    @(negedge clock);
    reset = rst; req_0 = r0; req_1 = r1; we_0 = w0; we_1 = w1;
    lock_0 = l0; lock_1 = l1; addr_0 = a0; addr_1 = a1; wdata_0 = d0; wdata_1 = d1;
    #1;
  endtask

  int          n0, ngrants;
  logic        got1, g;
  logic [6:0]  e0, e1;

  initial begin
    reset = 1'b1; req_0 = 1'b0; req_1 = 1'b0; we_0 = 1'b0; we_1 = 1'b0;
    lock_0 = 1'b0; lock_1 = 1'b0; addr_0 = '0; addr_1 = '0; wdata_0 = '0; wdata_1 = '0;

    //            rst r0 r1 w0 w1 l0 l1 a0        a1        d0        d1       ack0 ack1 wc rv0 rv1 rd0       rd1
    vt[0]  = '{Y, N, N, N, N, N, N, 16'h0000, 16'h0000, 16'h0000, 16'h0000, N, N, N, N, N, 16'h0000, 16'h0000};
    vt[1]  = '{Y, Y, Y, Y, Y, N, N, 16'h0010, 16'h0020, 16'h1111, 16'h2222, N, N, N, N, N, 16'h0000, 16'h0000};
    // simultaneous reads: requester 0 wins the first tie
    vt[2]  = '{N, Y, Y, N, N, N, N, 16'h0010, 16'h0020, 16'h0000, 16'h0000, Y, N, N, N, N, 16'h0000, 16'h0000};
    vt[3]  = '{N, N, Y, N, N, N, N, 16'h0010, 16'h0020, 16'h0000, 16'h0000, N, Y, N, Y, N, 16'hA010, 16'h0000};
    vt[4]  = '{N, N, N, N, N, N, N, 16'h0000, 16'h0000, 16'h0000, 16'h0000, N, N, N, N, Y, 16'h0000, 16'hA020};
    // write then read-back through the other requester
    vt[5]  = '{N, Y, N, Y, N, N, N, 16'h0042, 16'h0000, 16'hBEEF, 16'h0000, Y, N, Y, N, N, 16'h0000, 16'h0000};
    vt[6]  = '{N, N, Y, N, N, N, N, 16'h0000, 16'h0042, 16'h0000, 16'h0000, N, Y, N, N, N, 16'h0000, 16'h0000};
    vt[7]  = '{N, N, N, N, N, N, N, 16'h0000, 16'h0000, 16'h0000, 16'h0000, N, N, N, N, Y, 16'h0000, 16'hBEEF};
    // requester 1 locks, then drops: one dead cycle before requester 0
    vt[8]  = '{N, N, Y, N, N, N, Y, 16'h0000, 16'h0005, 16'h0000, 16'h0000, N, Y, N, N, N, 16'h0000, 16'h0000};
    vt[9]  = '{N, Y, N, N, N, N, N, 16'h0006, 16'h0000, 16'h0000, 16'h0000, N, N, N, N, Y, 16'h0000, 16'hA005};
    vt[10] = '{N, Y, N, N, N, N, N, 16'h0006, 16'h0000, 16'h0000, 16'h0000, Y, N, N, N, N, 16'h0000, 16'h0000};
    vt[11] = '{N, N, N, N, N, N, N, 16'h0000, 16'h0000, 16'h0000, 16'h0000, N, N, N, Y, N, 16'hA006, 16'h0000};
    // read accepted right before reset returns nothing
    vt[12] = '{N, Y, N, N, N, N, N, 16'h0007, 16'h0000, 16'h0000, 16'h0000, Y, N, N, N, N, 16'h0000, 16'h0000};
    vt[13] = '{Y, N, N, N, N, N, N, 16'h0000, 16'h0000, 16'h0000, 16'h0000, N, N, N, N, N, 16'h0000, 16'h0000};
    vt[14] = '{N, N, N, N, N, N, N, 16'h0000, 16'h0000, 16'h0000, 16'h0000, N, N, N, N, N, 16'h0000, 16'h0000};
    // reset during second beat of a locked burst abandons ownership
    vt[15] = '{N, Y, Y, N, N, Y, N, 16'h0008, 16'h0009, 16'h0000, 16'h0000, Y, N, N, N, N, 16'h0000, 16'h0000};
    vt[16] = '{Y, Y, Y, N, N, Y, N, 16'h0008, 16'h0009, 16'h0000, 16'h0000, N, N, N, N, N, 16'h0000, 16'h0000};
    vt[17] = '{N, N, Y, N, N, N, N, 16'h0008, 16'h0009, 16'h0000, 16'h0000, N, Y, N, N, N, 16'h0000, 16'h0000};
    vt[18] = '{N, Y, Y, N, N, N, N, 16'h0008, 16'h0009, 16'h0000, 16'h0000, Y, N, N, N, Y, 16'h0000, 16'hA009};
    vt[19] = '{N, N, N, N, N, N, N, 16'h0000, 16'h0000, 16'h0000, 16'h0000, N, N, N, Y, N, 16'hA008, 16'h0000};

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].rst, vt[i].r0, vt[i].r1, vt[i].w0, vt[i].w1, vt[i].l0, vt[i].l1,
            vt[i].a0, vt[i].a1, vt[i].d0, vt[i].d1);
      chk($sformatf("v%0d ack_0", i), 32'(ack_0), 32'(vt[i].e_ack0));
      chk($sformatf("v%0d ack_1", i), 32'(ack_1), 32'(vt[i].e_ack1));
      chk($sformatf("v%0d mem_write_ctrl", i), 32'(mem_write_ctrl), 32'(vt[i].e_wc));
      chk($sformatf("v%0d rvalid_0", i), 32'(rvalid_0), 32'(vt[i].e_rv0));
      chk($sformatf("v%0d rvalid_1", i), 32'(rvalid_1), 32'(vt[i].e_rv1));
      if (vt[i].e_rv0) chk($sformatf("v%0d rdata_0", i), 32'(rdata_0), 32'(vt[i].e_rd0));
      if (vt[i].e_rv1) chk($sformatf("v%0d rdata_1", i), 32'(rdata_1), 32'(vt[i].e_rd1));
    end

    // Locked burst capped at 4 beats: 0,0,0,0,1,0,0
    drive(Y, N, N, N, N, N, N, '0, '0, '0, '0);
    e0 = 7'b1101111;
    e1 = 7'b0010000;
    n0 = 0;
    got1 = 1'b0;
    for (int c = 0; c < 7; c++) begin
      drive(N, (n0 < 6) ? Y : N, got1 ? N : Y, N, N, Y, N, 16'h0030 + 16'(c), 16'h0031, '0, '0);
      chk($sformatf("burst c%0d ack_0", c), 32'(ack_0), 32'(e0[c]));
      chk($sformatf("burst c%0d ack_1", c), 32'(ack_1), 32'(e1[c]));
      if (ack_0) n0++;
      if (ack_1) got1 = 1'b1;
    end
    chk("burst total ack_0", 32'(n0), 32'd6);
    drive(N, N, N, N, N, N, N, '0, '0, '0, '0);
    chk("burst release ack_0", 32'(ack_0), 32'd0);

    // Alternating unlocked contention: 0 writes, 1 reads
    drive(Y, N, N, N, N, N, N, '0, '0, '0, '0);
    ngrants = 0;
    for (int c = 0; c < 20; c++) begin
      drive(N, Y, Y, Y, N, N, N, 16'h0080 + 16'(c), 16'h0090, 16'(c), '0);
      g = c[0];
      chk($sformatf("alt c%0d ack_0", c), 32'(ack_0), 32'(!g));
      chk($sformatf("alt c%0d ack_1", c), 32'(ack_1), 32'(g));
      chk($sformatf("alt c%0d mem_write_ctrl", c), 32'(mem_write_ctrl), 32'(!g));
      chk($sformatf("alt c%0d rvalid_1", c), 32'(rvalid_1), 32'((c > 0) && !g));
      if (ack_0) ngrants++;
      if (ack_1) ngrants++;
    end
    chk("alt total grants", 32'(ngrants), 32'd20);

    // Read back the last write of the alternating run (addr 0x92, data 18)
    drive(N, N, Y, N, N, N, N, '0, 16'h0092, '0, '0);
    chk("readback ack_1", 32'(ack_1), 32'd1);
    drive(N, N, N, N, N, N, N, '0, '0, '0, '0);
    chk("readback rvalid_1", 32'(rvalid_1), 32'd1);
    chk("readback rdata_1", 32'(rdata_1), 32'h0012);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
